// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared widths and types for the instruction-fetch front end.
//   INST_W / ADDR_W : instruction and byte-address widths
//   WORD_BYTES      : bytes per instruction word (fetch stride)
//   fetch_entry_t   : one prefetch-queue slot, {pc, inst}
//   FETCH_*         : per-cycle register-update mode of fetch_ctrl
// ---------------------------------------------------------------------------
package arm_pkg;

    localparam int INST_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Priority order is REDIRECT > FREEZE > RUN.
    localparam logic [1:0] FETCH_RUN      = 2'd0;
    localparam logic [1:0] FETCH_FREEZE   = 2'd1;
    localparam logic [1:0] FETCH_REDIRECT = 2'd2;

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO holding prefetched {pc, inst} entries.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : enqueue wr_data / dequeue head (both allowed in one cycle)
//   flush      : discard all entries and rewind both pointers to 0
//   wr_data    : entry written on push
//   head       : entry at the read pointer (meaningless when empty)
//   count      : number of valid entries, 0..DEPTH
//   full/empty : count == DEPTH / count == 0
// ---------------------------------------------------------------------------
module fetch_queue
    import arm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int             PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage is not reset: entries are only observed through head, and
    // the controller masks head whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = entries[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // The controller never overfills or underflows the queue.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer: owns the fetch PC, fills a prefetch queue
// from the instruction memory and hands {pc, inst} to decode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   mem_addr   : byte address to instruction memory (= fetch PC)
//   mem_inst   : instruction word at mem_addr, same cycle
//   freeze     : stall fetching; decode may still drain the queue
//   br_taken   : one-cycle redirect pulse, overrides everything else
//   br_addr    : redirect target, low two bits ignored
//   dec_valid  : queue head is valid
//   dec_ready  : decode accepts the head this cycle
//   dec_inst   : head instruction, 0 when not valid
//   dec_pc     : head byte address, 0 when not valid
// ---------------------------------------------------------------------------
module fetch_ctrl
    import arm_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    input  logic        freeze,
    input  logic        br_taken,
    input  logic [31:0] br_addr,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
);

    logic [ADDR_W-1:0]     fetch_pc;
    logic [ADDR_W-1:0]     redirect_pc;
    logic [1:0]            mode;
    logic                  push;
    logic                  pop;
    logic                  flush;
    fetch_entry_t          wr_entry;
    fetch_entry_t          q_head;
    logic [$clog2(DEPTH):0] q_count;
    logic                  q_full;
    logic                  q_empty;

    // Branch beats freeze, freeze beats normal fetching.
    always_comb begin
        mode = FETCH_RUN;
        if (br_taken) begin
            mode = FETCH_REDIRECT;
        end else if (freeze) begin
            mode = FETCH_FREEZE;
        end
    end

    // A pop frees a slot in the same cycle, so a full queue can still
    // accept a new word while decode is consuming (1 instr/cycle steady).
    assign pop   = !q_empty && dec_ready && (mode != FETCH_REDIRECT);
    assign push  = (mode == FETCH_RUN) && (!q_full || pop);
    assign flush = (mode == FETCH_REDIRECT);

    assign redirect_pc = br_addr & ~ADDR_W'(WORD_BYTES - 1);
    assign wr_entry    = '{pc: fetch_pc, inst: mem_inst};

    // Fetch PC only advances when a word is actually captured; addition
    // wraps 0xFFFFFFFC -> 0x00000000.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else begin
            case (mode)
                FETCH_REDIRECT: fetch_pc <= redirect_pc;
                FETCH_RUN: begin
                    if (push) begin
                        fetch_pc <= fetch_pc + ADDR_W'(WORD_BYTES);
                    end
                end
                default: fetch_pc <= fetch_pc;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_entry),
        .head    (q_head),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    assign mem_addr  = fetch_pc;
    assign dec_valid = !q_empty;
    assign dec_inst  = dec_valid ? q_head.inst : '0;
    assign dec_pc    = dec_valid ? q_head.pc   : '0;

    assert property (@(posedge clk) disable iff (!rst_n)
                     q_count <= ($clog2(DEPTH) + 1)'(DEPTH));

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl with an instruction-memory model.
// Stimulus pushes the {pc, inst} pairs decode is expected to accept into
// exp_q; a negedge monitor pops and compares on every accepted handshake.
// Timing-specific values (mem_addr, bubbles, flush behaviour) are checked
// directly by the stimulus one time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
    import arm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    int pass_checks  = 0;
    int total_checks = 0;

    fetch_entry_t exp_q [$];

    fetch_ctrl #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_inst  (mem_inst),
        .freeze    (freeze),
        .br_taken  (br_taken),
        .br_addr   (br_addr),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_inst  (dec_inst),
        .dec_pc    (dec_pc)
    );

    // Standard program: MOV R0,#20 ; MOV R1,#4096 ; then tagged filler
    // words 0xE28_00xxx where xxx is the word index (addr[13:2]).
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [29:0] w;
        w = addr[31:2];
        if (w == 30'd0) return 32'hE3A0_0014;
        if (w == 30'd1) return 32'hE3A0_1A01;
        return {20'hE2800, addr[13:2]};
    endfunction

    assign mem_inst = rom_word(mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual === expected) begin
            pass_checks++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic expectEntry(input logic [31:0] pc, input logic [31:0] inst);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge, then release with the given dec_ready.
    task automatic applyStimulus(input logic ready);
        rst_n     = 1'b0;
        dec_ready = 1'b0;
        freeze    = 1'b0;
        br_taken  = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        dec_ready = ready;
    endtask

    // Scoreboard monitor: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && dec_valid && dec_ready && !br_taken) begin
            if (exp_q.size() == 0) begin
                total_checks++;
                $display("[TB] FAIL sb_unexpected: got pc %h, expected no transfer", dec_pc);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                checkOutput("sb_pc", dec_pc, e.pc);
                checkOutput("sb_inst", dec_inst, e.inst);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        freeze    = 1'b0;
        br_taken  = 1'b0;
        br_addr   = 32'h0;
        dec_ready = 1'b0;

        #12;
        checkOutput("rst_mem_addr",  mem_addr,  32'h0);
        checkOutput("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
        checkOutput("rst_dec_inst",  dec_inst,  32'h0);
        checkOutput("rst_dec_pc",    dec_pc,    32'h0);

        // T1: release reset with decode ready
        $display("[TB] T1 reset release");
        expectEntry(32'h0, 32'hE3A0_0014);
        expectEntry(32'h4, 32'hE3A0_1A01);
        rst_n     = 1'b1;
        dec_ready = 1'b1;
        cycle();
        checkOutput("t1_valid0", {31'b0, dec_valid}, 32'h1);
        checkOutput("t1_pc0",    dec_pc,   32'h0);
        checkOutput("t1_inst0",  dec_inst, 32'hE3A0_0014);
        checkOutput("t1_addr0",  mem_addr, 32'h4);
        cycle();
        checkOutput("t1_valid1", {31'b0, dec_valid}, 32'h1);
        checkOutput("t1_pc1",    dec_pc,   32'h4);
        checkOutput("t1_inst1",  dec_inst, 32'hE3A0_1A01);
        cycle();
        checkOutput("t1_valid2", {31'b0, dec_valid}, 32'h1);
        checkOutput("t1_pc2",    dec_pc,   32'h8);
        dec_ready = 1'b0;

        // T2: backpressure fills the queue, then drain back-to-back
        $display("[TB] T2 backpressure");
        applyStimulus(1'b0);
        for (int i = 0; i < 10; i++) cycle();
        checkOutput("t2_addr_hold", mem_addr, 32'h10);
        checkOutput("t2_head_pc",   dec_pc,   32'h0);
        for (int i = 0; i < 5; i++) expectEntry(32'(4 * i), rom_word(32'(4 * i)));
        dec_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            checkOutput("t2_valid", {31'b0, dec_valid}, 32'h1);
            checkOutput("t2_pc",    dec_pc, 32'(4 * k));
        end

        // T3: redirect with three entries queued
        $display("[TB] T3 redirect");
        applyStimulus(1'b0);
        for (int i = 0; i < 3; i++) cycle();
        checkOutput("t3_addr_pre", mem_addr, 32'hC);
        expectEntry(32'h88, 32'hE280_0022);
        br_taken  = 1'b1;
        br_addr   = 32'h8B;
        dec_ready = 1'b1;
        cycle();
        br_taken = 1'b0;
        checkOutput("t3_bubble", {31'b0, dec_valid}, 32'h0);
        checkOutput("t3_addr",   mem_addr, 32'h88);
        cycle();
        checkOutput("t3_valid",  {31'b0, dec_valid}, 32'h1);
        checkOutput("t3_pc",     dec_pc,   32'h88);
        checkOutput("t3_inst",   dec_inst, 32'hE280_0022);
        cycle();
        checkOutput("t3_next_pc", dec_pc, 32'h8C);

        // T4: redirect beats freeze, then freeze alone
        $display("[TB] T4 freeze vs redirect");
        freeze   = 1'b1;
        br_taken = 1'b1;
        br_addr  = 32'h40;
        cycle();
        br_taken = 1'b0;
        freeze   = 1'b0;
        checkOutput("t4_bubble", {31'b0, dec_valid}, 32'h0);
        checkOutput("t4_addr",   mem_addr, 32'h40);
        cycle();
        checkOutput("t4_pc",     dec_pc,   32'h40);
        checkOutput("t4_addr2",  mem_addr, 32'h44);
        expectEntry(32'h40, 32'hE280_0010);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("t4_frz_addr",  mem_addr, 32'h44);
            checkOutput("t4_frz_valid", {31'b0, dec_valid}, 32'h0);
        end
        freeze    = 1'b0;
        dec_ready = 1'b0;

        // T5: full queue, simultaneous push and pop for 20 cycles
        $display("[TB] T5 full-queue streaming");
        for (int i = 0; i < 4; i++) cycle();
        checkOutput("t5_addr_full", mem_addr, 32'h54);
        checkOutput("t5_head",      dec_pc,   32'h44);
        for (int k = 0; k < 20; k++) expectEntry(32'h44 + 32'(4 * k), rom_word(32'h44 + 32'(4 * k)));
        dec_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            checkOutput("t5_pc",   dec_pc,   32'h44 + 32'(4 * k));
            checkOutput("t5_addr", mem_addr, 32'h54 + 32'(4 * k));
        end

        // T6: asynchronous reset mid-stream, then PC wrap-around
        $display("[TB] T6 async reset and wrap");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_valid", {31'b0, dec_valid}, 32'h0);
        checkOutput("t6_addr",  mem_addr, 32'h0);
        checkOutput("t6_pc",    dec_pc,   32'h0);
        dec_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        br_taken = 1'b1;
        br_addr  = 32'hFFFF_FFFF;
        cycle();
        br_taken = 1'b0;
        checkOutput("t6_br_addr", mem_addr, 32'hFFFF_FFFC);
        cycle();
        checkOutput("t6_top_pc",  dec_pc,   32'hFFFF_FFFC);
        checkOutput("t6_wrap",    mem_addr, 32'h0);
        expectEntry(32'hFFFF_FFFC, 32'hE280_0FFF);
        expectEntry(32'h0, 32'hE3A0_0014);
        dec_ready = 1'b1;
        cycle();
        checkOutput("t6_wrap_pc",   dec_pc,   32'h0);
        checkOutput("t6_wrap_inst", dec_inst, 32'hE3A0_0014);
        cycle();
        dec_ready = 1'b0;
        cycle();

        checkOutput("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
